// File: rtl/huff_pkg.sv
// rtl/huff_pkg.sv - shared parameters, FSM states and table-entry type for the Huffman decoder
package huff_pkg;

  localparam int NUM_SYM = 8;
  localparam int MAX_LEN = 7;
  localparam int CHAR_W  = 4;
  localparam int LEN_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DECODE
  } state_e;

  typedef struct packed {
    logic [CHAR_W-1:0]  chr;
    logic [LEN_W-1:0]   len;
    logic [MAX_LEN-1:0] code;
  } tbl_entry_t;

endpackage

// File: rtl/huff_match.sv
// rtl/huff_match.sv - combinational codeword lookup, lowest table index wins
module huff_match
  import huff_pkg::*;
(
  input  tbl_entry_t [NUM_SYM-1:0] tbl_i,
  input  logic [MAX_LEN-1:0]       acc_next_i,
  input  logic [LEN_W-1:0]         len_next_i,
  output logic                     hit_o,
  output logic [CHAR_W-1:0]        hit_char_o
);

  logic [MAX_LEN-1:0] mask;

  always_comb begin
    mask       = MAX_LEN'((32'd1 << len_next_i) - 32'd1);
    hit_o      = 1'b0;
    hit_char_o = '0;
    // Scan high to low so the last assignment comes from the lowest matching index.
    for (int i = NUM_SYM - 1; i >= 0; i--) begin
      if (tbl_i[i].len != '0 && tbl_i[i].len == len_next_i &&
          ((tbl_i[i].code ^ acc_next_i) & mask) == '0) begin
        hit_o      = 1'b1;
        hit_char_o = tbl_i[i].chr;
      end
    end
  end

endmodule

// File: rtl/huffman_decoder.sv
// rtl/huffman_decoder.sv - serial MSB-first Huffman decoder with loadable 8-entry code table
// Optional feature macro: HUFF_DEC_ERR_EN (drives err on overflow / truncated last codeword)
module huffman_decoder
  import huff_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tbl_valid,
  input  logic [CHAR_W-1:0]  tbl_char,
  input  logic [LEN_W-1:0]   tbl_len,
  input  logic [MAX_LEN-1:0] tbl_code,
  input  logic               bit_valid,
  input  logic               bit_in,
  input  logic               bit_last,
  output logic               busy,
  output logic               out_valid,
  output logic [CHAR_W-1:0]  out_char,
  output logic               err
);

`ifdef HUFF_DEC_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  state_e                   state_q, state_d;
  tbl_entry_t [NUM_SYM-1:0] tbl_q, tbl_d;
  logic [LEN_W-1:0]         load_cnt_q, load_cnt_d;
  logic [MAX_LEN-2:0]       acc_q, acc_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic                     out_valid_q, out_valid_d;
  logic [CHAR_W-1:0]        out_char_q, out_char_d;
  logic                     err_q, err_d;

  logic [MAX_LEN-1:0]       acc_next;
  logic [LEN_W-1:0]         len_next;
  logic                     hit;
  logic [CHAR_W-1:0]        hit_char;

  assign acc_next = {acc_q, bit_in};
  assign len_next = len_q + LEN_W'(1);

  huff_match u_match (
    .tbl_i      (tbl_q),
    .acc_next_i (acc_next),
    .len_next_i (len_next),
    .hit_o      (hit),
    .hit_char_o (hit_char)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tbl_q       <= '0;
      load_cnt_q  <= '0;
      acc_q       <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tbl_q       <= tbl_d;
      load_cnt_q  <= load_cnt_d;
      acc_q       <= acc_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tbl_d       = tbl_q;
    load_cnt_d  = load_cnt_q;
    acc_d       = acc_q;
    len_d       = len_q;
    out_valid_d = 1'b0;
    out_char_d  = out_char_q;
    err_d       = 1'b0;

    unique case (state_q)
      IDLE, LOAD: begin
        // load_cnt is always 0 in IDLE, so the first entry lands at index 0.
        if (tbl_valid) begin
          tbl_d[load_cnt_q] = {tbl_char, tbl_len, tbl_code};
          if (state_q == LOAD && load_cnt_q == LEN_W'(NUM_SYM - 1)) begin
            load_cnt_d = '0;
            state_d    = DECODE;
          end else begin
            load_cnt_d = load_cnt_q + LEN_W'(1);
            state_d    = LOAD;
          end
        end
      end
      DECODE: begin
        if (bit_valid) begin
          if (hit) begin
            out_valid_d = 1'b1;
            out_char_d  = hit_char;
            acc_d       = '0;
            len_d       = '0;
          end else if (len_next == LEN_W'(MAX_LEN) || bit_last) begin
            err_d = ERR_EN;
            acc_d = '0;
            len_d = '0;
          end else begin
            acc_d = acc_next[MAX_LEN-2:0];
            len_d = len_next;
          end
          if (bit_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_char  = out_char_q;
  assign err       = err_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// tb/tb_huffman_decoder.sv - directed self-checking bench for huffman_decoder
module tb_huffman_decoder;

`ifdef HUFF_DEC_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  localparam logic [3:0] CH_A = 4'hA, CH_B = 4'hB, CH_C = 4'hC, CH_D = 4'hD, CH_E = 4'hE;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tbl_valid;
  logic [3:0] tbl_char;
  logic [2:0] tbl_len;
  logic [6:0] tbl_code;
  logic       bit_valid, bit_in, bit_last;
  logic       busy, out_valid, err;
  logic [3:0] out_char;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] t_chr  [8];
  logic [2:0] t_len  [8];
  logic [6:0] t_code [8];

  huffman_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tbl_valid (tbl_valid),
    .tbl_char  (tbl_char),
    .tbl_len   (tbl_len),
    .tbl_code  (tbl_code),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .bit_last  (bit_last),
    .busy      (busy),
    .out_valid (out_valid),
    .out_char  (out_char),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_table();
    for (int i = 0; i < 8; i++) begin
      t_chr[i] = '0; t_len[i] = '0; t_code[i] = '0;
    end
  endtask

  task automatic set_table_t();
    clear_table();
    t_chr[0] = CH_A; t_len[0] = 3'd1; t_code[0] = 7'b0;
    t_chr[1] = CH_B; t_len[1] = 3'd2; t_code[1] = 7'b10;
    t_chr[2] = CH_C; t_len[2] = 3'd3; t_code[2] = 7'b110;
    t_chr[3] = CH_D; t_len[3] = 3'd3; t_code[3] = 7'b111;
  endtask

  task automatic load_table(input int gaps);
    for (int i = 0; i < 8; i++) begin
      tbl_valid = 1'b1; tbl_char = t_chr[i]; tbl_len = t_len[i]; tbl_code = t_code[i];
      step();
      tbl_valid = 1'b0;
      for (int g = 0; g < gaps; g++) step();
    end
  endtask

  task automatic send_bit(input string tag, input logic b, input logic last,
                          input logic exp_v, input logic [3:0] exp_c, input logic exp_e);
    bit_valid = 1'b1; bit_in = b; bit_last = last;
    step();
    bit_valid = 1'b0; bit_last = 1'b0;
    chk({tag, "_valid"}, 32'(out_valid), 32'(exp_v));
    chk({tag, "_err"}, 32'(err), 32'(exp_e));
    if (exp_v) chk({tag, "_char"}, 32'(out_char), 32'(exp_c));
  endtask

  initial begin
    rst_n = 1'b0; tbl_valid = 1'b0; tbl_char = '0; tbl_len = '0; tbl_code = '0;
    bit_valid = 1'b0; bit_in = 1'b0; bit_last = 1'b0;
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_char", 32'(out_char), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic stream A B C D
    set_table_t();
    load_table(0);
    chk("t1_busy_load", 32'(busy), 32'd1);
    send_bit("t1_b1", 1'b0, 1'b0, 1'b1, CH_A, 1'b0);
    send_bit("t1_b2", 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    send_bit("t1_b3", 1'b0, 1'b0, 1'b1, CH_B, 1'b0);
    send_bit("t1_b4", 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    send_bit("t1_b5", 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    send_bit("t1_b6", 1'b0, 1'b0, 1'b1, CH_C, 1'b0);
    send_bit("t1_b7", 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    send_bit("t1_b8", 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    send_bit("t1_b9", 1'b1, 1'b1, 1'b1, CH_D, 1'b0);
    chk("t1_busy_end", 32'(busy), 32'd0);
    step();
    chk("t1_pulse_len", 32'(out_valid), 32'd0);
    chk("t1_char_hold", 32'(out_char), 32'(CH_D));

    // Bits outside DECODE are ignored
    send_bit("idle_bit", 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);

    // Gapped load, back-to-back 1-bit codes
    tbl_valid = 1'b1; tbl_char = t_chr[0]; tbl_len = t_len[0]; tbl_code = t_code[0];
    step();
    tbl_valid = 1'b0;
    step(); step();
    chk("t2_busy_gap", 32'(busy), 32'd1);
    for (int i = 1; i < 8; i++) begin
      tbl_valid = 1'b1; tbl_char = t_chr[i]; tbl_len = t_len[i]; tbl_code = t_code[i];
      step();
      tbl_valid = 1'b0;
      step();
    end
    send_bit("t2_b1", 1'b0, 1'b0, 1'b1, CH_A, 1'b0);
    send_bit("t2_b2", 1'b0, 1'b0, 1'b1, CH_A, 1'b0);
    send_bit("t2_b3", 1'b0, 1'b1, 1'b1, CH_A, 1'b0);
    chk("t2_busy_end", 32'(busy), 32'd0);

    // Overflow at MAX_LEN with single-entry table
    clear_table();
    t_chr[0] = CH_A; t_len[0] = 3'd1; t_code[0] = 7'b0;
    load_table(0);
    for (int i = 1; i <= 6; i++) send_bit($sformatf("t3_b%0d", i), 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    send_bit("t3_b7", 1'b1, 1'b0, 1'b0, 4'h0, ERR_EXP);
    send_bit("t3_after", 1'b0, 1'b1, 1'b1, CH_A, 1'b0);

    // Truncated last codeword
    set_table_t();
    load_table(0);
    send_bit("t4_b1", 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    send_bit("t4_b2", 1'b1, 1'b1, 1'b0, 4'h0, ERR_EXP);
    chk("t4_busy", 32'(busy), 32'd0);
    step();
    chk("t4_err_pulse", 32'(err), 32'd0);

    // Duplicate codes: lower index wins
    set_table_t();
    t_chr[2] = CH_E; t_len[2] = 3'd2; t_code[2] = 7'b10;
    load_table(0);
    send_bit("t5_b1", 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    send_bit("t5_b2", 1'b0, 1'b1, 1'b1, CH_B, 1'b0);

    // Reset mid-decode, then stream without reload
    set_table_t();
    load_table(0);
    send_bit("t6_b1", 1'b0, 1'b0, 1'b1, CH_A, 1'b0);
    send_bit("t6_b2", 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_char", 32'(out_char), 32'd0);
    chk("t6_rst_err", 32'(err), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    send_bit("t6_s1", 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    send_bit("t6_s2", 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    send_bit("t6_s3", 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    chk("t6_busy_end", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
